// File: rtl/decode_pkg.sv
// Shared decode definitions for the ID/EX control pipe: opcodes, ResultSrc/ALUOp
// encodings and the packed control bundle captured in the ID/EX register.
package decode_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam int unsigned ALUOP_ENC_W = 3;
    localparam int unsigned REG_FIELD_W = 5;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } res_t;

    typedef enum logic [ALUOP_ENC_W-1:0] {
        ALU_R     = 3'd0,
        ALU_I     = 3'd1,
        ALU_BR    = 3'd2,
        ALU_ADD   = 3'd3,
        ALU_OTHER = 3'd4
    } aluop_t;

    typedef struct packed {
        logic                   regwrite;
        logic                   alusrc;
        logic                   memread;
        logic                   memwrite;
        logic                   branch;
        logic                   jump;
        logic                   jalr;
        res_t                   resultsrc;
        aluop_t                 aluop;
        logic [REG_FIELD_W-1:0] rd;
        logic [REG_FIELD_W-1:0] rs1;
        logic [REG_FIELD_W-1:0] rs2;
        logic [2:0]             funct3;
        logic                   illegal;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Combinational opcode -> ctrl_t decoder with rs1/rs2 usage flags.
// Register fields are zeroed where the instruction format has no such field.
module ctrl_decode_comb
    import decode_pkg::*;
(
    input  logic [31:0] i_instr,
    output ctrl_t       o_ctrl,
    output logic        o_rs1_used,
    output logic        o_rs2_used
);

    logic [6:0] w_op;
    logic       w_rd_used;
    logic       w_unused;

    assign w_op     = i_instr[6:0];
    assign w_unused = ^i_instr[31:25];

    always_comb begin
        o_ctrl        = '0;
        o_ctrl.aluop  = ALU_OTHER;
        o_ctrl.funct3 = i_instr[14:12];
        o_rs1_used    = 1'b0;
        o_rs2_used    = 1'b0;
        unique case (w_op)
            OP_R: begin
                o_ctrl.regwrite = 1'b1;
                o_ctrl.aluop    = ALU_R;
                o_rs1_used      = 1'b1;
                o_rs2_used      = 1'b1;
            end
            OP_I: begin
                o_ctrl.regwrite = 1'b1;
                o_ctrl.alusrc   = 1'b1;
                o_ctrl.aluop    = ALU_I;
                o_rs1_used      = 1'b1;
            end
            OP_LOAD: begin
                o_ctrl.regwrite  = 1'b1;
                o_ctrl.alusrc    = 1'b1;
                o_ctrl.memread   = 1'b1;
                o_ctrl.resultsrc = RES_MEM;
                o_ctrl.aluop     = ALU_ADD;
                o_rs1_used       = 1'b1;
            end
            OP_S: begin
                o_ctrl.alusrc   = 1'b1;
                o_ctrl.memwrite = 1'b1;
                o_ctrl.aluop    = ALU_ADD;
                o_rs1_used      = 1'b1;
                o_rs2_used      = 1'b1;
            end
            OP_B: begin
                o_ctrl.branch = 1'b1;
                o_ctrl.aluop  = ALU_BR;
                o_rs1_used    = 1'b1;
                o_rs2_used    = 1'b1;
            end
            OP_JAL: begin
                o_ctrl.regwrite  = 1'b1;
                o_ctrl.jump      = 1'b1;
                o_ctrl.resultsrc = RES_PC4;
            end
            OP_JALR: begin
                o_ctrl.regwrite  = 1'b1;
                o_ctrl.alusrc    = 1'b1;
                o_ctrl.jump      = 1'b1;
                o_ctrl.jalr      = 1'b1;
                o_ctrl.resultsrc = RES_PC4;
                o_ctrl.aluop     = ALU_ADD;
                o_rs1_used       = 1'b1;
            end
            OP_LUI: begin
                o_ctrl.regwrite  = 1'b1;
                o_ctrl.resultsrc = RES_IMM;
            end
            OP_AUIPC: begin
                o_ctrl.regwrite = 1'b1;
                o_ctrl.alusrc   = 1'b1;
                o_ctrl.aluop    = ALU_ADD;
            end
            default: o_ctrl.illegal = 1'b1;
        endcase
        // Every writing opcode has an rd field; nothing else does.
        w_rd_used  = o_ctrl.regwrite;
        o_ctrl.rd  = w_rd_used  ? i_instr[11:7]  : '0;
        o_ctrl.rs1 = o_rs1_used ? i_instr[19:15] : '0;
        o_ctrl.rs2 = o_rs2_used ? i_instr[24:20] : '0;
    end

endmodule

// File: rtl/id_ex_ctrl_pipe.sv
// ID/EX control register with valid/ready handshake, load-use bubble and flush kill.
// Optional perf counters (stall_count, flush_count) under DECODE_PERF_CNT_EN.
module id_ex_ctrl_pipe
    import decode_pkg::*;
#(
    parameter int unsigned ALUOP_W    = 3,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [31:0]           id_instr,
    output logic                  id_ready,
    input  logic                  ex_ready,
    input  logic                  flush,
    output logic                  hazard_stall,
    output logic                  ex_valid,
    output logic                  ex_regwrite,
    output logic                  ex_alusrc,
    output logic                  ex_memread,
    output logic                  ex_memwrite,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic                  ex_jalr,
    output logic [1:0]            ex_resultsrc,
    output logic [ALUOP_W-1:0]    ex_aluop,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic [2:0]            ex_funct3,
    output logic                  ex_illegal
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]           stall_count,
    output logic [31:0]           flush_count
`endif
);

    ctrl_t w_dec;
    logic  w_rs1_used;
    logic  w_rs2_used;
    logic  w_hold;
    logic  w_rs1_hit;
    logic  w_rs2_hit;
    logic  r_valid;
    ctrl_t r_ctrl;

    ctrl_decode_comb u_decode (
        .i_instr    (id_instr),
        .o_ctrl     (w_dec),
        .o_rs1_used (w_rs1_used),
        .o_rs2_used (w_rs2_used)
    );

    assign w_rs1_hit    = w_rs1_used & (w_dec.rs1 == r_ctrl.rd);
    assign w_rs2_hit    = w_rs2_used & (w_dec.rs2 == r_ctrl.rd);
    assign hazard_stall = r_valid & r_ctrl.memread & (r_ctrl.rd != '0) & id_valid
                        & (w_rs1_hit | w_rs2_hit);
    assign w_hold       = r_valid & ~ex_ready;
    assign id_ready     = ~rst & (flush | (~w_hold & ~hazard_stall));

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (w_hold) begin
            r_valid <= r_valid;
            r_ctrl  <= r_ctrl;
        end else if (hazard_stall) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else begin
            r_valid <= id_valid;
            r_ctrl  <= w_dec;
        end
    end

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] r_stall_count;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (hazard_stall && !flush) r_stall_count <= r_stall_count + 32'd1;
            if (flush)                  r_flush_count <= r_flush_count + 32'd1;
        end
    end

    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;
`endif

    assign ex_valid     = r_valid;
    assign ex_regwrite  = r_ctrl.regwrite;
    assign ex_alusrc    = r_ctrl.alusrc;
    assign ex_memread   = r_ctrl.memread;
    assign ex_memwrite  = r_ctrl.memwrite;
    assign ex_branch    = r_ctrl.branch;
    assign ex_jump      = r_ctrl.jump;
    assign ex_jalr      = r_ctrl.jalr;
    assign ex_resultsrc = r_ctrl.resultsrc;
    assign ex_aluop     = ALUOP_W'(r_ctrl.aluop);
    assign ex_rd        = REG_ADDR_W'(r_ctrl.rd);
    assign ex_rs1       = REG_ADDR_W'(r_ctrl.rs1);
    assign ex_rs2       = REG_ADDR_W'(r_ctrl.rs2);
    assign ex_funct3    = r_ctrl.funct3;
    assign ex_illegal   = r_ctrl.illegal;

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Randomized self-checking bench for id_ex_ctrl_pipe against a behavioural model
// of the ID/EX entry; counters are also checked when DECODE_PERF_CNT_EN is defined.
module tb_id_ex_ctrl_pipe;

    logic        clk = 1'b0;
    logic        rst, id_valid, ex_ready, flush;
    logic [31:0] id_instr;
    logic        id_ready, hazard_stall, ex_valid;
    logic        ex_regwrite, ex_alusrc, ex_memread, ex_memwrite;
    logic        ex_branch, ex_jump, ex_jalr, ex_illegal;
    logic [1:0]  ex_resultsrc;
    logic [2:0]  ex_aluop, ex_funct3;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;
`ifdef DECODE_PERF_CNT_EN
    logic [31:0] stall_count, flush_count;
    int unsigned m_stalls, m_flushes;
`endif

    always #5 clk = ~clk;

    id_ex_ctrl_pipe #(.ALUOP_W(3), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
        .id_ready(id_ready), .ex_ready(ex_ready), .flush(flush),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid),
        .ex_regwrite(ex_regwrite), .ex_alusrc(ex_alusrc), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_jalr(ex_jalr), .ex_resultsrc(ex_resultsrc), .ex_aluop(ex_aluop),
        .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_funct3(ex_funct3),
        .ex_illegal(ex_illegal)
`ifdef DECODE_PERF_CNT_EN
        , .stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        bit       v, rw, as, mr, mw, br, j, jr, il;
        bit [1:0] res;
        bit [2:0] op;
        bit [4:0] rd, rs1, rs2;
        bit [2:0] f3;
        bit       u1, u2;
    } ent_t;

    ent_t m;

    // Instruction classes from the opcode table, then fields from the class rules.
    function automatic ent_t decode(input bit [31:0] ins);
        ent_t e;
        string k;
        e = '{default: 0};
        case (ins[6:0])
            7'h33: k = "R";    7'h13: k = "I";     7'h03: k = "LD";
            7'h23: k = "S";    7'h63: k = "B";     7'h6F: k = "JAL";
            7'h67: k = "JALR"; 7'h37: k = "LUI";   7'h17: k = "AUIPC";
            default: k = "ILL";
        endcase
        e.il = (k == "ILL");
        e.rw = (k == "R" || k == "I" || k == "LD" || k == "JAL" || k == "JALR" ||
                k == "LUI" || k == "AUIPC");
        e.as = (k == "I" || k == "LD" || k == "S" || k == "JALR" || k == "AUIPC");
        e.mr = (k == "LD");
        e.mw = (k == "S");
        e.br = (k == "B");
        e.j  = (k == "JAL" || k == "JALR");
        e.jr = (k == "JALR");
        e.res = (k == "LD") ? 2'd1 : (e.j ? 2'd2 : ((k == "LUI") ? 2'd3 : 2'd0));
        e.op = (k == "R") ? 3'd0 : (k == "I") ? 3'd1 : (k == "B") ? 3'd2 :
               (k == "LD" || k == "S" || k == "AUIPC" || k == "JALR") ? 3'd3 : 3'd4;
        e.u1 = (k == "R" || k == "I" || k == "LD" || k == "S" || k == "B" || k == "JALR");
        e.u2 = (k == "R" || k == "S" || k == "B");
        e.rd  = e.rw ? ins[11:7]  : 5'd0;
        e.rs1 = e.u1 ? ins[19:15] : 5'd0;
        e.rs2 = e.u2 ? ins[24:20] : 5'd0;
        e.f3  = ins[14:12];
        return e;
    endfunction

    function automatic logic [63:0] pack(input ent_t e);
        return {32'd0, e.v, e.rw, e.as, e.mr, e.mw, e.br, e.j, e.jr, e.res, e.op,
                e.rd, e.rs1, e.rs2, e.f3, e.il};
    endfunction

    function automatic logic [63:0] dut_vec();
        return {32'd0, ex_valid, ex_regwrite, ex_alusrc, ex_memread, ex_memwrite,
                ex_branch, ex_jump, ex_jalr, ex_resultsrc, ex_aluop,
                ex_rd, ex_rs1, ex_rs2, ex_funct3, ex_illegal};
    endfunction

    bit last_hz;

    task automatic step(input bit r, input bit v, input bit [31:0] ins,
                        input bit rdy, input bit fl);
        ent_t d;
        bit   hz, hold;
        @(negedge clk);
        rst = r; id_valid = v; id_instr = ins; ex_ready = rdy; flush = fl;
        #1;
        d   = decode(ins);
        d.v = v;
        hz  = m.v && m.mr && (m.rd != 0) && v &&
              ((d.u1 && d.rs1 == m.rd) || (d.u2 && d.rs2 == m.rd));
        hold = m.v && !rdy;
        last_hz = hz;
        check("hazard_stall", {63'd0, hazard_stall}, {63'd0, hz});
        check("id_ready", {63'd0, id_ready}, {63'd0, !r && (fl || (!hold && !hz))});
`ifdef DECODE_PERF_CNT_EN
        if (r) begin
            m_stalls = 0; m_flushes = 0;
        end else begin
            if (hz && !fl) m_stalls++;
            if (fl) m_flushes++;
        end
`endif
        if (r || fl)   m = '{default: 0};
        else if (hold) m = m;
        else if (hz)   m = '{default: 0};
        else           m = d;
        @(posedge clk);
        #1;
        check("ex_entry", dut_vec(), pack(m));
`ifdef DECODE_PERF_CNT_EN
        check("stall_count", {32'd0, stall_count}, {32'd0, m_stalls});
        check("flush_count", {32'd0, flush_count}, {32'd0, m_flushes});
`endif
    endtask

    localparam bit [31:0] ADD_3_1_2 = 32'h002081B3;
    localparam bit [31:0] LW_5_1    = 32'h0000A283;
    localparam bit [31:0] ADD_6_5_2 = 32'h00228333;
    localparam bit [31:0] LW_0_1    = 32'h0000A003;
    localparam bit [31:0] ADD_6_0_2 = 32'h00200333;
    localparam bit [31:0] ADDI_1    = 32'h00108093;
    localparam bit [31:0] SW_2_1    = 32'h0020A023;
    localparam bit [31:0] ILL_7F    = 32'h0000007F;

    bit [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                          7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};

    initial begin
        m = '{default: 0};
        rst = 1'b1; id_valid = 1'b0; id_instr = '0; ex_ready = 1'b1; flush = 1'b0;
        step(1, 0, 0, 1, 0);
        step(1, 1, ADD_3_1_2, 1, 0);
        check("reset_zero", dut_vec(), 64'd0);

        step(0, 1, ADD_3_1_2, 1, 0);
        check("add_fields", {59'd0, ex_valid, ex_regwrite, ex_resultsrc == 2'b00,
                             ex_aluop == 3'd0, ex_rd == 5'd3}, 64'h1F);

        step(0, 1, LW_5_1, 1, 0);
        step(0, 1, ADD_6_5_2, 1, 0);
        check("lu_stalled", {63'd0, last_hz}, 64'd1);
        check("lu_bubble", {63'd0, ex_valid}, 64'd0);
        step(0, 1, ADD_6_5_2, 1, 0);
        check("lu_add_in_ex", {58'd0, ex_valid, ex_rd}, {58'd0, 1'b1, 5'd6});

        step(0, 1, LW_0_1, 1, 0);
        step(0, 1, ADD_6_0_2, 1, 0);
        check("x0_no_stall", {63'd0, last_hz}, 64'd0);

        step(0, 1, SW_2_1, 1, 0);
        step(0, 1, ADDI_1, 0, 1);
        check("flush_kill", {63'd0, ex_valid}, 64'd0);

        step(0, 1, SW_2_1, 1, 0);
        for (int unsigned i = 0; i < 3; i++) begin
            step(0, 1, ADDI_1, 0, 0);
            check("hold_sw", {63'd0, ex_memwrite}, 64'd1);
        end
        step(0, 1, ADDI_1, 1, 0);
        check("release", {61'd0, ex_valid, ex_alusrc, ex_aluop == 3'd1}, 64'h7);

        step(0, 1, ILL_7F, 1, 0);
        check("illegal", {61'd0, ex_illegal, ex_regwrite, ex_memwrite}, 64'h4);
        step(0, 1, SW_2_1, 1, 0);
        step(0, 1, ADDI_1, 0, 0);
        step(1, 1, ADDI_1, 0, 0);
        check("rst_mid_hold", dut_vec(), 64'd0);

        for (int unsigned i = 0; i < 3000; i++) begin
            bit [31:0] ins;
            ins        = $urandom;
            ins[6:0]   = (($urandom % 8) == 0) ? 7'($urandom) : ops[$urandom % 10];
            ins[11:7]  = 5'($urandom_range(0, 3));
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            step(($urandom % 60) == 0, ($urandom % 5) != 0, ins,
                 ($urandom % 4) != 0, ($urandom % 12) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
